axis_rate_window_ctrl: RTL and testbench

- Multi-channel measurement-window controller for the AXI-Stream bit-rate sniffing datapath.
- Counts handshaken beats (valid && ready) on NUM_CH monitored streams over a programmable window, snapshots all channels on the same cycle, and converts beats to bits.
- Drains results one channel at a time over a valid/ready result port to the register/readback logic.
- Supports one-shot and continuous windows, abort, and overrun detection when readback stalls.

---
 rtl/axis_rate_pkg.sv | 15 +
 rtl/axis_beat_counter.sv | 26 ++
 rtl/axis_rate_window_ctrl.sv | 130 +++++++++++++
 tb/tb_axis_rate_window_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_rate_pkg.sv
// Shared types and width helpers for the AXI-Stream rate window controller.
package axis_rate_pkg;

  typedef enum logic {W_IDLE, W_RUN} win_state_t;
  typedef enum logic {D_IDLE, D_SEND} drn_state_t;

  function automatic int res_width(input int counter_width, input int data_width);
    return counter_width + $clog2(data_width);
  endfunction

  function automatic int idx_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/axis_beat_counter.sv
// Per-channel saturating beat counter; snap is the count including this cycle's beat.
module axis_beat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             beat,
  output logic [WIDTH-1:0] snap
);

  logic [WIDTH-1:0] count;

  always_comb begin
    snap = count;
    if (beat && (count != '1)) snap = count + WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= snap;
  end

endmodule

// File: rtl/axis_rate_window_ctrl.sv
// Multi-channel measurement-window controller: counts handshaken beats per window,
// snapshots all channels together and drains them as bit counts over a valid/ready port.
module axis_rate_window_ctrl
  import axis_rate_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int DATA_WIDTH    = 256,
  parameter int COUNTER_WIDTH = 32,
  parameter int WINDOW_WIDTH  = 32
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_CH-1:0]                             mon_valid,
  input  logic [NUM_CH-1:0]                             mon_ready,
  input  logic [WINDOW_WIDTH-1:0]                       cfg_window,
  input  logic                                          cfg_continuous,
  input  logic                                          cfg_start,
  input  logic                                          cfg_stop,
  output logic                                          res_valid,
  input  logic                                          res_ready,
  output logic [idx_width(NUM_CH)-1:0]                  res_ch,
  output logic [res_width(COUNTER_WIDTH,DATA_WIDTH)-1:0] res_bits,
  output logic                                          busy,
  output logic                                          overrun,
  output logic [15:0]                                   window_count
);

  localparam int CHW   = idx_width(NUM_CH);
  localparam int RW    = res_width(COUNTER_WIDTH, DATA_WIDTH);
  localparam int SHIFT = $clog2(DATA_WIDTH);
  localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH - 1);

  win_state_t win_state, win_next;
  drn_state_t drn_state, drn_next;

  logic [WINDOW_WIDTH-1:0]  win_cnt, win_load;
  logic [CHW-1:0]           ch_idx;
  logic [COUNTER_WIDTH-1:0] snap_val [NUM_CH];
  logic [COUNTER_WIDTH-1:0] snap_q   [NUM_CH];
  logic beat_en, beat_clr, start_ok, win_end, last_accept, drain_free, take_snap;

  // A zero window length behaves as a one-cycle window.
  assign win_load    = (cfg_window == '0) ? '0 : cfg_window - WINDOW_WIDTH'(1);
  assign start_ok    = (win_state == W_IDLE) && cfg_start && !cfg_stop;
  assign beat_en     = (win_state == W_RUN);
  assign win_end     = beat_en && !cfg_stop && (win_cnt == '0);
  assign beat_clr    = start_ok || win_end || (beat_en && cfg_stop);
  assign last_accept = (drn_state == D_SEND) && res_ready && (ch_idx == LAST_CH);
  // A drain finishing this cycle frees the snapshot store for a same-cycle window end.
  assign drain_free  = (drn_state == D_IDLE) || last_accept;
  assign take_snap   = win_end && drain_free;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    axis_beat_counter #(.WIDTH(COUNTER_WIDTH)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (beat_clr),
      .en    (beat_en),
      .beat  (mon_valid[g] & mon_ready[g]),
      .snap  (snap_val[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) win_state <= W_IDLE;
    else       win_state <= win_next;
  end

  always_comb begin
    win_next = win_state;
    case (win_state)
      W_IDLE:  if (start_ok) win_next = W_RUN;
      W_RUN:   if (cfg_stop || (win_end && !cfg_continuous)) win_next = W_IDLE;
      default: win_next = W_IDLE;
    endcase
  end

  always_comb begin
    busy = (win_state == W_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt      <= '0;
      window_count <= '0;
      overrun      <= 1'b0;
    end else begin
      if (start_ok || (win_end && cfg_continuous)) win_cnt <= win_load;
      else if (beat_en && (win_cnt != '0))         win_cnt <= win_cnt - WINDOW_WIDTH'(1);
      if (win_end) window_count <= window_count + 16'd1;
      if (start_ok)                     overrun <= 1'b0;
      else if (win_end && !drain_free)  overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drn_state <= D_IDLE;
    else       drn_state <= drn_next;
  end

  always_comb begin
    drn_next = drn_state;
    case (drn_state)
      D_IDLE:  if (take_snap) drn_next = D_SEND;
      D_SEND:  if (last_accept && !take_snap) drn_next = D_IDLE;
      default: drn_next = D_IDLE;
    endcase
  end

  always_comb begin
    res_valid = (drn_state == D_SEND);
    res_ch    = ch_idx;
    res_bits  = RW'(snap_q[ch_idx]) << SHIFT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_idx <= '0;
      for (int i = 0; i < NUM_CH; i++) snap_q[i] <= '0;
    end else begin
      if (take_snap) begin
        ch_idx <= '0;
        for (int i = 0; i < NUM_CH; i++) snap_q[i] <= snap_val[i];
      end else if (res_valid && res_ready) begin
        ch_idx <= ch_idx + CHW'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_rate_window_ctrl.sv
// Directed bench for axis_rate_window_ctrl with hand-computed record values.
module tb_axis_rate_window_ctrl;

  localparam int NCH  = 4;
  localparam int CHW  = 2;
  localparam int RW   = 40;
  localparam int SRW  = 12;
  localparam int RECW = CHW + RW;
  localparam int SREC = CHW + SRW;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NCH-1:0]  mon_valid = '0, mon_ready = '0;
  logic [31:0]     cfg_window = '0;
  logic            cfg_continuous = 1'b0, cfg_start = 1'b0, cfg_stop = 1'b0;
  logic            res_ready = 1'b1;
  logic            res_valid, busy, overrun;
  logic [CHW-1:0]  res_ch;
  logic [RW-1:0]   res_bits;
  logic [15:0]     window_count;
  logic            s_res_valid, s_busy, s_overrun;
  logic [CHW-1:0]  s_res_ch;
  logic [SRW-1:0]  s_res_bits;
  logic [15:0]     s_window_count;

  logic [RECW-1:0] got_q[$], exp_q[$];
  logic [SREC-1:0] sgot_q[$], sexp_q[$];
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  axis_rate_window_ctrl dut (
    .clk(clk), .reset(reset), .mon_valid(mon_valid), .mon_ready(mon_ready),
    .cfg_window(cfg_window), .cfg_continuous(cfg_continuous), .cfg_start(cfg_start),
    .cfg_stop(cfg_stop), .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
    .res_bits(res_bits), .busy(busy), .overrun(overrun), .window_count(window_count)
  );

  axis_rate_window_ctrl #(.COUNTER_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset), .mon_valid(mon_valid), .mon_ready(mon_ready),
    .cfg_window(cfg_window), .cfg_continuous(cfg_continuous), .cfg_start(cfg_start),
    .cfg_stop(cfg_stop), .res_valid(s_res_valid), .res_ready(res_ready), .res_ch(s_res_ch),
    .res_bits(s_res_bits), .busy(s_busy), .overrun(s_overrun), .window_count(s_window_count)
  );

  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) got_q.push_back({res_ch, res_bits});
    if (!reset && s_res_valid && res_ready) sgot_q.push_back({s_res_ch, s_res_bits});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mon_valid = '0; mon_ready = '0;
    cfg_start = 1'b0; cfg_stop = 1'b0; cfg_continuous = 1'b0; res_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    got_q.delete(); sgot_q.delete(); exp_q.delete(); sexp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++;
    if ({res_valid, busy, overrun, window_count} !== 19'd0)
      $display("FAIL reset_state: valid %b busy %b ovr %b wc %0d required all 0", res_valid, busy, overrun, window_count);
    else passes++;
    do_reset();
  endtask

  task automatic test_basic();
    logic [RECW-1:0] e, g;
    do_reset();
    cfg_window = 100; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      mon_valid = {1'b0, 1'b1, (i % 2 == 0), 1'b1};
      mon_ready = {1'b0, 1'b0, (i % 2 == 0), 1'b1};
      step();
    end
    mon_valid = '0; mon_ready = '0;
    checks++;
    if (busy !== 1'b0 || window_count !== 16'd1 || res_valid !== 1'b1)
      $display("FAIL basic_end: busy %b wc %0d valid %b required 0 1 1", busy, window_count, res_valid);
    else passes++;
    exp_q = '{{2'd0, 40'd25600}, {2'd1, 40'd12800}, {2'd2, 40'd0}, {2'd3, 40'd0}};
    for (int i = 0; i < 40 && got_q.size() < 4; i++) step();
    repeat (4) step();
    checks++;
    if (got_q.size() != 4) $display("FAIL basic_count: records %0d required 4", got_q.size());
    else passes++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) $display("FAIL basic_rec: ch %0d bits %0d required ch %0d bits %0d", g[RW+:CHW], g[RW-1:0], e[RW+:CHW], e[RW-1:0]);
      else passes++;
    end
  endtask

  task automatic test_boundary();
    logic [RECW-1:0] e, g;
    for (int w = 1; w >= 0; w--) begin
      do_reset();
      cfg_window = w; cfg_start = 1'b1;
      step();
      cfg_start = 1'b0; mon_valid = 4'b0001; mon_ready = 4'b0001;
      step();
      mon_valid = '0; mon_ready = '0;
      checks++;
      if (res_valid !== 1'b1 || res_ch !== 2'd0 || res_bits !== 40'd256 || busy !== 1'b0)
        $display("FAIL boundary_first w=%0d: valid %b ch %0d bits %0d busy %b required 1 0 256 0", w, res_valid, res_ch, res_bits, busy);
      else passes++;
      exp_q = '{{2'd0, 40'd256}, {2'd1, 40'd0}, {2'd2, 40'd0}, {2'd3, 40'd0}};
      for (int i = 0; i < 20 && got_q.size() < 4; i++) step();
      repeat (4) step();
      checks++;
      if (got_q.size() != 4 || window_count !== 16'd1)
        $display("FAIL boundary_count w=%0d: records %0d wc %0d required 4 1", w, got_q.size(), window_count);
      else passes++;
      while (exp_q.size() > 0 && got_q.size() > 0) begin
        e = exp_q.pop_front(); g = got_q.pop_front();
        checks++;
        if (g !== e) $display("FAIL boundary_rec w=%0d: ch %0d bits %0d required ch %0d bits %0d", w, g[RW+:CHW], g[RW-1:0], e[RW+:CHW], e[RW-1:0]);
        else passes++;
      end
    end
  endtask

  task automatic test_continuous_backpressure();
    logic [RECW-1:0] e, g;
    do_reset();
    res_ready = 1'b0; cfg_window = 4; cfg_continuous = 1'b1; cfg_start = 1'b1;
    mon_valid = 4'b0001; mon_ready = 4'b0001;
    step();
    cfg_start = 1'b0;
    for (int j = 0; j < 20; j++) begin
      mon_valid[2] = (j + 2 > 5); mon_ready[2] = (j + 2 > 5);
      step();
      if (j == 8) begin
        checks++;
        if (res_valid !== 1'b1 || res_ch !== 2'd0 || res_bits !== 40'd1024)
          $display("FAIL stall_hold: valid %b ch %0d bits %0d required 1 0 1024", res_valid, res_ch, res_bits);
        else passes++;
      end
    end
    checks++;
    if (overrun !== 1'b1 || window_count !== 16'd5 || res_bits !== 40'd1024 || res_ch !== 2'd0 || busy !== 1'b1)
      $display("FAIL stall_end: ovr %b wc %0d bits %0d ch %0d busy %b required 1 5 1024 0 1", overrun, window_count, res_bits, res_ch, busy);
    else passes++;
    cfg_continuous = 1'b0; res_ready = 1'b1; mon_valid[1] = 1'b1; mon_ready[1] = 1'b1;
    repeat (4) step();
    mon_valid = '0; mon_ready = '0;
    checks++;
    if (busy !== 1'b0 || window_count !== 16'd6 || overrun !== 1'b1)
      $display("FAIL cont_stop: busy %b wc %0d ovr %b required 0 6 1", busy, window_count, overrun);
    else passes++;
    exp_q = '{{2'd0, 40'd1024}, {2'd1, 40'd0}, {2'd2, 40'd0}, {2'd3, 40'd0},
              {2'd0, 40'd1024}, {2'd1, 40'd1024}, {2'd2, 40'd1024}, {2'd3, 40'd0}};
    for (int i = 0; i < 30 && got_q.size() < 8; i++) step();
    repeat (4) step();
    checks++;
    if (got_q.size() != 8) $display("FAIL cont_count: records %0d required 8", got_q.size());
    else passes++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) $display("FAIL cont_rec: ch %0d bits %0d required ch %0d bits %0d", g[RW+:CHW], g[RW-1:0], e[RW+:CHW], e[RW-1:0]);
      else passes++;
    end
  endtask

  // Continues from the state left by test_continuous_backpressure (overrun=1, window_count=6).
  task automatic test_abort();
    logic [RECW-1:0] e, g;
    mon_valid = 4'b0001; mon_ready = 4'b0001;
    cfg_start = 1'b1; cfg_stop = 1'b1;
    step();
    cfg_start = 1'b0; cfg_stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b1)
      $display("FAIL start_stop_idle: busy %b ovr %b required 0 1", busy, overrun);
    else passes++;
    cfg_window = 50; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    checks++;
    if (busy !== 1'b1 || overrun !== 1'b0)
      $display("FAIL start_clears: busy %b ovr %b required 1 0", busy, overrun);
    else passes++;
    repeat (49) step();
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0;
    repeat (8) step();
    checks++;
    if (busy !== 1'b0 || window_count !== 16'd6 || res_valid !== 1'b0 || got_q.size() != 0)
      $display("FAIL abort: busy %b wc %0d valid %b records %0d required 0 6 0 0", busy, window_count, res_valid, got_q.size());
    else passes++;
    cfg_window = 3; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    repeat (3) step();
    mon_valid = '0; mon_ready = '0;
    exp_q = '{{2'd0, 40'd768}, {2'd1, 40'd0}, {2'd2, 40'd0}, {2'd3, 40'd0}};
    for (int i = 0; i < 20 && got_q.size() < 4; i++) step();
    repeat (4) step();
    checks++;
    if (got_q.size() != 4 || window_count !== 16'd7)
      $display("FAIL after_abort_count: records %0d wc %0d required 4 7", got_q.size(), window_count);
    else passes++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) $display("FAIL after_abort_rec: ch %0d bits %0d required ch %0d bits %0d", g[RW+:CHW], g[RW-1:0], e[RW+:CHW], e[RW-1:0]);
      else passes++;
    end
  endtask

  task automatic test_saturation();
    logic [SREC-1:0] e, g;
    do_reset();
    cfg_window = 40; mon_valid = 4'b0001; mon_ready = 4'b0001; cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    repeat (40) step();
    mon_valid = '0; mon_ready = '0;
    sexp_q = '{{2'd0, 12'd3840}, {2'd1, 12'd0}, {2'd2, 12'd0}, {2'd3, 12'd0}};
    for (int i = 0; i < 20 && sgot_q.size() < 4; i++) step();
    repeat (4) step();
    checks++;
    if (sgot_q.size() != 4 || got_q.size() == 0 || got_q[0] !== {2'd0, 40'd10240})
      $display("FAIL sat_count: records %0d wide_ch0 %0d required 4 10240", sgot_q.size(), (got_q.size() > 0) ? got_q[0][RW-1:0] : 40'd0);
    else passes++;
    while (sexp_q.size() > 0 && sgot_q.size() > 0) begin
      e = sexp_q.pop_front(); g = sgot_q.pop_front();
      checks++;
      if (g !== e) $display("FAIL sat_rec: ch %0d bits %0d required ch %0d bits %0d", g[SRW+:CHW], g[SRW-1:0], e[SRW+:CHW], e[SRW-1:0]);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    res_ready = 1'b0; cfg_window = 1; cfg_continuous = 1'b1; cfg_start = 1'b1;
    mon_valid = 4'b0011; mon_ready = 4'b0011;
    step();
    cfg_start = 1'b0;
    step(); step();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    step();
    checks++;
    if (res_valid !== 1'b1 || res_ch !== 2'd1 || busy !== 1'b1 || overrun !== 1'b1)
      $display("FAIL pre_reset: valid %b ch %0d busy %b ovr %b required 1 1 1 1", res_valid, res_ch, busy, overrun);
    else passes++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || window_count !== 16'd0)
      $display("FAIL async_reset: valid %b busy %b ovr %b wc %0d required 0 0 0 0", res_valid, busy, overrun, window_count);
    else passes++;
    got_q.delete();
    cfg_continuous = 1'b0; mon_valid = '0; mon_ready = '0; res_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    repeat (10) step();
    checks++;
    if (got_q.size() != 0 || window_count !== 16'd0 || res_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL post_reset: records %0d wc %0d valid %b busy %b required 0 0 0 0", got_q.size(), window_count, res_valid, busy);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_continuous_backpressure();
    test_abort();
    test_saturation();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
